uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
- Byte queue sitting directly upstream of the UART top's transmit side, in the system clock domain.
- Buffers up to DEPTH words from a producer and drains them into the UART one at a time.
- Drives the UART's Tx_in/send inputs and paces itself on its Tx_ready output.
- The UART registers send on the slow baud clock, so this block holds send level-high until the transmitter acknowledges by dropping Tx_ready.

Parameters:
- WORD_LENGHT, 8, width of each queued word; must match the UART's WORD_LENGHT.
- DEPTH, 16, queue entries; power of two, 2..256.
- SYNC_STAGES, 2, flops in the Tx_ready synchronizer; minimum 2.

Ports:
- clk  input  1  system clock; same clock as the UART's clk.
- rst  input  1  asynchronous, active-low reset.
- wr_data  input  WORD_LENGHT  word to enqueue.
- wr_en  input  1  enqueue strobe, one word per cycle high.
- full  output  1  queue holds DEPTH words.
- empty  output  1  queue holds 0 words.
- overflow  output  1  sticky: a write was dropped.
- ovf_clr  input  1  clears overflow.
- tx_data  output  WORD_LENGHT  connects to the UART's Tx_in.
- tx_send  output  1  connects to the UART's send.
- tx_ready  input  1  from the UART's Tx_ready; asynchronous to clk.
- busy  output  1  high while a word is in flight (FSM not IDLE).

Behaviour:
- Reset (rst=0, asynchronous): state returns to IDLE and both pointers go to 0.
  - Outputs at reset: empty=1, full=0, overflow=0, tx_send=0, tx_data=0, busy=0.
  - Synchronizer flops reset to 0.
  - Reset mid-transfer abandons the word; queue contents are lost.
- Storage: circular buffer with read/write pointers of log2(DEPTH)+1 bits, so the extra MSB resolves full vs empty.
  - Pointers wrap modulo 2*DEPTH.
  - full and empty are registered, updated the same cycle as the pointers.
- Write rules:
  - wr_en=1 and full=0: word stored, write pointer increments.
  - wr_en=1 and full=1: word dropped, overflow set on the next edge.
  - overflow holds until ovf_clr=1. If set and clear coincide, set wins.
  - A write with a simultaneous pop while full is still dropped; full is evaluated before the pop.
- Synchronizer: tx_ready passes through SYNC_STAGES flops to give rdy_s. The FSM uses only rdy_s.
- FSM states:
  - IDLE: if empty=0 and rdy_s=1, go to LOAD.
  - LOAD: tx_data <= mem[rd_ptr]; rd_ptr increments; go to REQ.
    - The pop is visible in full/empty on the next cycle.
    - A write arriving the same cycle as the pop is accepted normally when full=0.
  - REQ: tx_send=1, tx_data stable. Stay until rdy_s=0, then go to DRAIN.
  - DRAIN: tx_send=0. Stay until rdy_s=1, then go to IDLE.
- tx_data is stable from LOAD until the next LOAD and never changes while tx_send=1.
- Latency: an enqueue into an empty queue with rdy_s=1 raises tx_send 2 cycles after the write edge (IDLE→LOAD→REQ).
- Back-to-back: the next LOAD requires returning through IDLE with rdy_s=1, so there is at most one word per UART frame.
- rdy_s=0 while in IDLE (UART busy from another source): the block waits and does not pop.
- No timeout: REQ waits indefinitely.

Optional Feature:
- Macro: UART_TXQ_LEVEL_EN.
- When defined:
  - Adds output port level, width log2(DEPTH)+1: the registered count of stored words, 0..DEPTH.
  - level updates in the same cycle as full/empty.
  - level resets to 0.
  - Simultaneous accepted write and LOAD pop leave level unchanged.
- When not defined: the level port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset with rst=0 mid-REQ, carrying 3 queued words → empty=1, tx_send=0, busy=0, overflow=0 immediately (asynchronous); no further tx_send after release.
- Single byte: write 8'hA5 with tx_ready=1.
  - Expect tx_send=1 with tx_data=8'hA5 two cycles later; it holds until tx_ready is driven 0.
  - tx_send falls on the cycle after rdy_s=0; busy drops after tx_ready returns to 1 (+SYNC_STAGES).
- Ordering: write 8'h01..8'h05 back-to-back; a UART model acks each.
  - Words are sent in order 01,02,03,04,05, each with exactly one REQ phase.
  - empty=1 after the fifth LOAD.
- Full/overflow: with tx_ready held 0, write 17 words (DEPTH=16).
  - full=1 after the 16th; the 17th is dropped and overflow=1.
  - ovf_clr pulse gives overflow=0; ovf_clr and a dropped write in the same cycle give overflow=1.
- Wrap-around: with tx_ready=1, push and drain 40 words (ramp 0..39) through a DEPTH=16 queue → all 40 are received in order, with no spurious full/empty.
- UART_TXQ_LEVEL_EN build: write 3 words with tx_ready=0 → level=3; write while LOAD pops → level stays 3; drain all → level=0.

Source files
------------

// File: rtl/uart_tx_queue.sv
// Transmit-side byte queue feeding a UART: buffers DEPTH words and hands them over one per frame.
// Optional macro UART_TXQ_LEVEL_EN adds the registered fill-level output port 'level'.
module uart_tx_queue #(
  parameter int WORD_LENGHT = 8,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_LENGHT-1:0] wr_data,
  input  logic                   wr_en,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  input  logic                   ovf_clr,
  output logic [WORD_LENGHT-1:0] tx_data,
  output logic                   tx_send,
  input  logic                   tx_ready,
  output logic                   busy
`ifdef UART_TXQ_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_REQ   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WORD_LENGHT-1:0] r_mem [DEPTH];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [PW-1:0]          w_wr_ptr_nxt;
  logic [PW-1:0]          w_rd_ptr_nxt;
  logic                   r_full;
  logic                   r_empty;
  logic                   w_full_nxt;
  logic                   w_empty_nxt;
  logic                   r_overflow;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rdy_s;
  logic [WORD_LENGHT-1:0] r_tx_data;
  logic                   r_tx_send;
  logic                   r_busy;
  logic                   w_push;
  logic                   w_pop;

  // Full is judged on the current registered flag, so a write racing a pop while full is dropped.
  assign w_push       = wr_en & ~r_full;
  assign w_pop        = (r_state == S_LOAD);
  assign w_wr_ptr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push};
  assign w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};
  assign w_full_nxt   = (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                        (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
  assign w_empty_nxt  = (w_wr_ptr_nxt == w_rd_ptr_nxt);
  assign w_rdy_s      = r_sync[SYNC_STAGES-1];

  assign full     = r_full;
  assign empty    = r_empty;
  assign overflow = r_overflow;
  assign tx_data  = r_tx_data;
  assign tx_send  = r_tx_send;
  assign busy     = r_busy;

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // Pointers, flags and the sticky overflow (set wins over clear).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= {PW{1'b0}};
      r_rd_ptr   <= {PW{1'b0}};
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_full   <= w_full_nxt;
      r_empty  <= w_empty_nxt;
      if (wr_en && r_full) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Tx_ready crosses from the UART's baud domain through a plain flop chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], tx_ready};
    end
  end

  // Handshake state register plus registered copies of the state-derived outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_tx_send <= 1'b0;
      r_busy    <= 1'b0;
      r_tx_data <= {WORD_LENGHT{1'b0}};
    end else begin
      r_state   <= w_state_nxt;
      r_tx_send <= (w_state_nxt == S_REQ);
      r_busy    <= (w_state_nxt != S_IDLE);
      if (w_pop) begin
        r_tx_data <= r_mem[r_rd_ptr[AW-1:0]];
      end
    end
  end

  // send is held until the UART acknowledges by dropping ready, then ready must return.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!r_empty && w_rdy_s) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (!w_rdy_s) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_DRAIN: begin
        if (w_rdy_s) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef UART_TXQ_LEVEL_EN
  logic [PW-1:0] r_level;

  assign level = r_level;

  // Fill count moves in step with the pointers; a simultaneous push and pop cancel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level <= {PW{1'b0}};
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + {{AW{1'b0}}, 1'b1};
        2'b01:   r_level <= r_level - {{AW{1'b0}}, 1'b1};
        default: r_level <= r_level;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: vector table for full/overflow plus hand-written handshake sequences.
module tb_uart_tx_queue;

  localparam int WL = 8;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic [WL-1:0] wr_data;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          ovf_clr;
  logic [WL-1:0] tx_data;
  logic          tx_send;
  logic          tx_ready;
  logic          busy;
`ifdef UART_TXQ_LEVEL_EN
  logic [4:0]    level;
`endif

  uart_tx_queue #(.WORD_LENGHT(WL), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .overflow(overflow), .ovf_clr(ovf_clr),
    .tx_data(tx_data), .tx_send(tx_send), .tx_ready(tx_ready), .busy(busy)
`ifdef UART_TXQ_LEVEL_EN
    , .level(level)
`endif
  );

  typedef struct {
    logic          wr_en;
    logic [WL-1:0] wr_data;
    logic          ovf_clr;
    logic          exp_full;
    logic          exp_empty;
    logic          exp_ovf;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WL-1:0] rx_q[$];
  logic          prev_send;
  logic [WL-1:0] held_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    tick();
  endtask

  // UART model: capture each new send, check tx_data holds while send is high.
  always @(negedge clk) begin
    if (!rst) begin
      prev_send <= 1'b0;
    end else begin
      if (tx_send && !prev_send) begin
        rx_q.push_back(tx_data);
        held_data <= tx_data;
      end else if (tx_send && prev_send) begin
        chk("tx_data_stable", {24'd0, tx_data}, {24'd0, held_data});
      end
      prev_send <= tx_send;
    end
  end

  task automatic drain(input int n, input bit chk_empty);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      while (!tx_send && t < 300) begin
        tick();
        t++;
      end
      chk("drain_send_seen", {31'd0, tx_send}, 32'd1);
      if (chk_empty) chk("empty_at_load", {31'd0, empty}, {31'd0, (k == n - 1)});
      tx_ready = 1'b0;
      t = 0;
      while (tx_send && t < 300) begin
        tick();
        t++;
      end
      chk("drain_send_fell", {31'd0, tx_send}, 32'd0);
      tx_ready = 1'b1;
    end
  endtask

  task automatic write_word(input logic [WL-1:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    vec_t vecs[21];
    bit   seen;
    int   t;

    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{1'b1, 8'(8'h30 + i), 1'b0, (i == 15), 1'b0, 1'b0};
    end
    vecs[16] = '{1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 8'hDD, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0; tx_ready = 1'b1;
    #12;
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_send", {31'd0, tx_send}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Single byte with exact latency and handshake timing.
    do_reset();
    write_word(8'hA5);
    chk("sb_empty_after_wr", {31'd0, empty}, 32'd0);
    chk("sb_send_e0", {31'd0, tx_send}, 32'd0);
    tick();
    chk("sb_busy_load", {31'd0, busy}, 32'd1);
    chk("sb_send_e1", {31'd0, tx_send}, 32'd0);
    tick();
    chk("sb_send_e2", {31'd0, tx_send}, 32'd1);
    chk("sb_data", {24'd0, tx_data}, 32'hA5);
    chk("sb_empty_after_pop", {31'd0, empty}, 32'd1);
    tick(); tick();
    chk("sb_send_hold", {31'd0, tx_send}, 32'd1);
    tx_ready = 1'b0;
    tick(); tick();
    chk("sb_send_until_rdy_s", {31'd0, tx_send}, 32'd1);
    tick();
    chk("sb_send_fall", {31'd0, tx_send}, 32'd0);
    chk("sb_busy_drain", {31'd0, busy}, 32'd1);
    tx_ready = 1'b1;
    tick(); tick();
    chk("sb_busy_wait", {31'd0, busy}, 32'd1);
    tick();
    chk("sb_busy_done", {31'd0, busy}, 32'd0);

    // Ordering of five back-to-back writes.
    do_reset();
    rx_q.delete();
    for (int i = 1; i <= 5; i++) write_word(8'(i));
    drain(5, 1'b1);
    tick(); tick(); tick(); tick();
    chk("ord_count", rx_q.size(), 32'd5);
    for (int i = 0; i < 5; i++) if (i < rx_q.size()) chk("ord_data", {24'd0, rx_q[i]}, i + 1);

    // Full/overflow table with the UART holding ready low.
    tx_ready = 1'b0;
    do_reset();
    rx_q.delete();
    for (int i = 0; i < 21; i++) begin
      wr_en = vecs[i].wr_en; wr_data = vecs[i].wr_data; ovf_clr = vecs[i].ovf_clr;
      tick();
      chk("tbl_full", {31'd0, full}, {31'd0, vecs[i].exp_full});
      chk("tbl_empty", {31'd0, empty}, {31'd0, vecs[i].exp_empty});
      chk("tbl_ovf", {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
      chk("tbl_busy", {31'd0, busy}, 32'd0);
    end
    wr_en = 1'b0; ovf_clr = 1'b0;
    tx_ready = 1'b1;
    drain(16, 1'b0);
    tick(); tick(); tick(); tick();
    chk("full_drain_count", rx_q.size(), 32'd16);
    for (int i = 0; i < 16; i++) if (i < rx_q.size()) chk("full_drain_data", {24'd0, rx_q[i]}, 32'h30 + i);
    chk("full_drain_empty", {31'd0, empty}, 32'd1);

    // Reset in the middle of a request with words still queued.
    do_reset();
    for (int i = 0; i < 4; i++) write_word(8'h50 + 8'(i));
    t = 0;
    while (!tx_send && t < 50) begin tick(); t++; end
    chk("rr_in_req", {31'd0, tx_send}, 32'd1);
    rst = 1'b0;
    #2;
    chk("rr_empty", {31'd0, empty}, 32'd1);
    chk("rr_send", {31'd0, tx_send}, 32'd0);
    chk("rr_busy", {31'd0, busy}, 32'd0);
    chk("rr_ovf", {31'd0, overflow}, 32'd0);
    tick(); tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin tick(); if (tx_send) seen = 1'b1; end
    chk("rr_no_send_after", {31'd0, seen}, 32'd0);

    // Wrap-around: 40-word ramp with producer throttled by full.
    do_reset();
    rx_q.delete();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int w = 0;
          while (full && w < 300) begin tick(); w++; end
          write_word(8'(i));
        end
      end
      drain(40, 1'b0);
    join
    tick(); tick(); tick(); tick();
    chk("wrap_count", rx_q.size(), 32'd40);
    for (int i = 0; i < 40; i++) if (i < rx_q.size()) chk("wrap_data", {24'd0, rx_q[i]}, i);
    chk("wrap_ovf", {31'd0, overflow}, 32'd0);
    chk("wrap_empty", {31'd0, empty}, 32'd1);
    chk("wrap_full", {31'd0, full}, 32'd0);

`ifdef UART_TXQ_LEVEL_EN
    tx_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) write_word(8'h70 + 8'(i));
    chk("lvl_three", {27'd0, level}, 32'd3);
    tx_ready = 1'b1;
    t = 0;
    while (!busy && t < 20) begin tick(); t++; end
    chk("lvl_in_load", {31'd0, busy}, 32'd1);
    write_word(8'h7F);
    chk("lvl_push_pop", {27'd0, level}, 32'd3);
    drain(4, 1'b0);
    tick(); tick(); tick(); tick();
    chk("lvl_zero", {27'd0, level}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
